// File: rtl/famicom_pkg.sv
// Shared definitions for the Famicom/NES controller logic.
//   fc_state_t       : pad reader FSM states
//   FC_BTN_A..RIGHT  : button positions in the serial stream / button byte
package famicom_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StGap,
        StPulseHi,
        StPulseLo,
        StDone
    } fc_state_t;

    // Serial order of a standard pad; the pad-emulation shift register uses the same order.
    localparam int unsigned FC_BTN_A      = 0;
    localparam int unsigned FC_BTN_B      = 1;
    localparam int unsigned FC_BTN_SELECT = 2;
    localparam int unsigned FC_BTN_START  = 3;
    localparam int unsigned FC_BTN_UP     = 4;
    localparam int unsigned FC_BTN_DOWN   = 5;
    localparam int unsigned FC_BTN_LEFT   = 6;
    localparam int unsigned FC_BTN_RIGHT  = 7;

endpackage

// File: rtl/famicom_pad_reader_if.sv
// Signal bundle between the pad reader, the controller pins and the core.
//   enable    : core -> reader, permits new transactions
//   pad_data  : pad  -> reader, serial data, low = pressed
//   pad_latch : reader -> pad, latch strobe
//   pad_pulse : reader -> pad, shift clock
//   buttons   : reader -> core, 1 = pressed, bit i = i-th serial bit
//   valid     : reader -> core, one-cycle strobe when buttons updates
//   busy      : reader -> core, transaction in progress
// master = reader side, slave = pad/core side.
interface famicom_pad_reader_if #(
    parameter int unsigned NUM_BITS = 8
);
    logic                enable;
    logic                pad_data;
    logic                pad_latch;
    logic                pad_pulse;
    logic [NUM_BITS-1:0] buttons;
    logic                valid;
    logic                busy;

    modport master (
        input  enable,
        input  pad_data,
        output pad_latch,
        output pad_pulse,
        output buttons,
        output valid,
        output busy
    );

    modport slave (
        output enable,
        output pad_data,
        input  pad_latch,
        input  pad_pulse,
        input  buttons,
        input  valid,
        input  busy
    );
endinterface

// File: rtl/famicom_pad_reader_sync2.sv
// Two-flop synchronizer with a parameterized reset value.
//   clk_sys : clock
//   reset   : synchronous active-high reset, loads RESET_VALUE into both flops
//   d       : asynchronous input
//   q       : synchronized output (two clocks of latency)
module sync2 #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/famicom_pad_reader.sv
// Famicom/NES controller reader: polls the pad every POLL_PERIOD clocks by driving latch
// and pulse, samples the serial data stream and presents an active-high button word.
//   clk_sys : clock, all logic on rising edge
//   reset   : synchronous active-high reset
//   bus     : master side of famicom_pad_reader_if (enable, pad pins, buttons/valid/busy)
// bus must be instantiated with the same NUM_BITS as this module.
module famicom_pad_reader
    import famicom_pkg::*;
#(
    parameter int unsigned NUM_BITS     = 8,
    parameter int unsigned LATCH_CYCLES = 600,
    parameter int unsigned HALF_CYCLES  = 300,
    parameter int unsigned POLL_PERIOD  = 833_333
) (
    input logic                  clk_sys,
    input logic                  reset,
    famicom_pad_reader_if.master bus
);
    localparam int unsigned TXN_CYCLES =
        LATCH_CYCLES + HALF_CYCLES + (NUM_BITS - 1) * 2 * HALF_CYCLES + 1;
    localparam int unsigned PHASE_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int unsigned PHASE_W   = $clog2(PHASE_MAX + 1);
    localparam int unsigned POLL_W    = $clog2(POLL_PERIOD + 1);
    localparam int unsigned IDX_W     = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

    localparam logic [PHASE_W-1:0] LATCH_LOAD = PHASE_W'(LATCH_CYCLES - 1);
    localparam logic [PHASE_W-1:0] HALF_LOAD  = PHASE_W'(HALF_CYCLES - 1);
    localparam logic [POLL_W-1:0]  POLL_LAST  = POLL_W'(POLL_PERIOD - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_BITS - 1);

    // A transaction must finish before the next tick, otherwise polls would be skipped.
    if (POLL_PERIOD <= TXN_CYCLES + 1) begin : g_bad_poll
        $fatal(1, "famicom_pad_reader: POLL_PERIOD must exceed transaction length + 1");
    end
    if (NUM_BITS < 1 || NUM_BITS > 16) begin : g_bad_bits
        $fatal(1, "famicom_pad_reader: NUM_BITS must be 1..16");
    end
    if (LATCH_CYCLES < 1 || HALF_CYCLES < 1) begin : g_bad_timing
        $fatal(1, "famicom_pad_reader: LATCH_CYCLES and HALF_CYCLES must be nonzero");
    end

    fc_state_t           state_q;
    logic [PHASE_W-1:0]  phase_q;
    logic [POLL_W-1:0]   poll_q;
    logic [IDX_W-1:0]    idx_q;
    logic [NUM_BITS-1:0] shift_q;
    logic [NUM_BITS-1:0] shift_sampled;
    logic [NUM_BITS-1:0] buttons_q;
    logic                latch_q;
    logic                pulse_q;
    logic                valid_q;
    logic                data_sync;
    logic                tick;
    logic                phase_done;

    // Idle line is high (released), so an unplugged pad reads as no buttons.
    sync2 #(
        .RESET_VALUE (1'b1)
    ) u_pad_sync (
        .clk_sys (clk_sys),
        .reset   (reset),
        .d       (bus.pad_data),
        .q       (data_sync)
    );

    assign tick       = (poll_q == POLL_LAST);
    assign phase_done = (phase_q == '0);

    // Shift register with the current sample dropped into slot idx_q; raw line levels.
    always_comb begin
        shift_sampled = shift_q;
        for (int unsigned i = 0; i < NUM_BITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                shift_sampled[i] = data_sync;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q   <= StIdle;
            phase_q   <= '0;
            poll_q    <= '0;
            idx_q     <= '0;
            shift_q   <= '1;
            buttons_q <= '0;
            latch_q   <= 1'b0;
            pulse_q   <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            poll_q  <= tick ? '0 : poll_q + POLL_W'(1);
            valid_q <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (tick && bus.enable) begin
                        state_q <= StLatch;
                        phase_q <= LATCH_LOAD;
                        latch_q <= 1'b1;
                        idx_q   <= '0;
                    end
                end
                StLatch: begin
                    if (phase_done) begin
                        state_q <= StGap;
                        phase_q <= HALF_LOAD;
                        latch_q <= 1'b0;
                    end else begin
                        phase_q <= phase_q - PHASE_W'(1);
                    end
                end
                StPulseHi: begin
                    if (phase_done) begin
                        state_q <= StPulseLo;
                        phase_q <= HALF_LOAD;
                        pulse_q <= 1'b0;
                    end else begin
                        phase_q <= phase_q - PHASE_W'(1);
                    end
                end
                // GAP samples bit 0 (idx_q is 0), PULSE_LO samples bit idx_q.
                StGap, StPulseLo: begin
                    if (phase_done) begin
                        shift_q <= shift_sampled;
                        if (idx_q == IDX_LAST) begin
                            state_q   <= StDone;
                            buttons_q <= ~shift_sampled;
                            valid_q   <= 1'b1;
                        end else begin
                            state_q <= StPulseHi;
                            phase_q <= HALF_LOAD;
                            pulse_q <= 1'b1;
                            idx_q   <= idx_q + IDX_W'(1);
                        end
                    end else begin
                        phase_q <= phase_q - PHASE_W'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    latch_q <= 1'b0;
                    pulse_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pad_latch = latch_q;
    assign bus.pad_pulse = pulse_q;
    assign bus.buttons   = buttons_q;
    assign bus.valid     = valid_q;
    assign bus.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_famicom_pad_reader.sv
module tb_famicom_pad_reader;
    localparam int unsigned L    = 4;
    localparam int unsigned H    = 3;
    localparam int unsigned P    = 100;
    localparam int unsigned N    = 8;
    localparam int unsigned TXN  = L + H + (N - 1) * 2 * H + 1;
    localparam int unsigned TXN1 = L + H + 1;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    always #5 clk_sys = ~clk_sys;

    famicom_pad_reader_if #(.NUM_BITS(N)) bus ();
    famicom_pad_reader_if #(.NUM_BITS(1)) bus1 ();

    famicom_pad_reader #(
        .NUM_BITS     (N),
        .LATCH_CYCLES (L),
        .HALF_CYCLES  (H),
        .POLL_PERIOD  (P)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus.master)
    );

    famicom_pad_reader #(
        .NUM_BITS     (1),
        .LATCH_CYCLES (L),
        .HALF_CYCLES  (H),
        .POLL_PERIOD  (P)
    ) dut1 (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus1.master)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Clock-edge count and the edge at which reset was last sampled high.
    int cyc     = 0;
    int rst_cyc = 0;
    always @(posedge clk_sys) begin
        cyc++;
        if (reset) rst_cyc = cyc;
    end

    // ---------------- pad models + reference (expected pushes) ----------------
    // mode 0: pad plugged holding pat; 1: unplugged (line high); 2: line stuck low
    int            mode = 0;
    logic [N-1:0]  pat  = '0;
    logic [N-1:0]  pad_sr = '0;
    logic          pat1 = 1'b0;
    logic [N-1:0]  exp_q[$];
    logic          exp1_q[$];

    always @(posedge bus.pad_latch or posedge bus.pad_pulse) begin
        if (bus.pad_latch) begin
            logic [N-1:0] e;
            pad_sr = pat;
            e = (mode == 1) ? '0 : (mode == 2) ? '1 : pat;
            exp_q.push_back(e);
        end else begin
            pad_sr = pad_sr >> 1;
        end
    end
    assign bus.pad_data = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : ~pad_sr[0];

    always @(posedge bus1.pad_latch) exp1_q.push_back(pat1);
    assign bus1.pad_data = ~pat1;
    assign bus1.enable   = 1'b1;

    // ---------------- monitor for the 8-bit reader ----------------
    logic lat_d = 1'b0, pul_d = 1'b0, en_d = 1'b0, exp_busy = 1'b0;
    int   lat_rise = 0, pul_rise = 0, pul_fall = 0, pulses = 0;
    int   valid_cnt = 0, latch_cnt = 0;

    always @(negedge clk_sys) begin
        if (rst_cyc == cyc) begin
            exp_q.delete();
            exp_busy = 1'b0;
            pulses   = 0;
        end else begin
            if (bus.pad_latch && !lat_d) begin
                latch_cnt++;
                lat_rise = cyc;
                check("latch_on_tick", (cyc - rst_cyc) % P, 0);
                check("latch_enable", en_d, 1);
                check("latch_while_busy", exp_busy, 0);
                exp_busy = 1'b1;
                pulses   = 0;
            end
            if (!bus.pad_latch && lat_d) check("latch_width", cyc - lat_rise, L);
            if (bus.pad_pulse && !pul_d) begin
                pulses++;
                if (pulses == 1) check("gap_width", cyc - (lat_rise + L), H);
                else check("pulse_low", cyc - pul_fall, H);
                pul_rise = cyc;
            end
            if (!bus.pad_pulse && pul_d) begin
                check("pulse_high", cyc - pul_rise, H);
                pul_fall = cyc;
            end
            check("busy", bus.busy, exp_busy);
            if (bus.valid) begin
                valid_cnt++;
                if (exp_q.size() == 0) begin
                    check("valid_unexpected", 1, 0);
                end else begin
                    logic [N-1:0] e;
                    e = exp_q.pop_front();
                    check("buttons", bus.buttons, e);
                end
                check("valid_cycle", cyc - lat_rise + 1, TXN);
                check("pulse_count", pulses, N - 1);
                exp_busy = 1'b0;
            end
        end
        lat_d = bus.pad_latch;
        pul_d = bus.pad_pulse;
        en_d  = bus.enable;
    end

    // ---------------- monitor for the 1-bit reader ----------------
    logic lat1_d = 1'b0;
    int   lat1_rise = 0, valid1_cnt = 0, latch1_cnt = 0;

    always @(negedge clk_sys) begin
        if (rst_cyc == cyc) begin
            exp1_q.delete();
        end else begin
            if (bus1.pad_latch && !lat1_d) begin
                latch1_cnt++;
                lat1_rise = cyc;
            end
            check("n1_no_pulse", bus1.pad_pulse, 0);
            if (bus1.valid) begin
                valid1_cnt++;
                if (exp1_q.size() == 0) begin
                    check("n1_valid_unexpected", 1, 0);
                end else begin
                    logic e1;
                    e1 = exp1_q.pop_front();
                    check("n1_buttons", bus1.buttons, e1);
                end
                check("n1_valid_cycle", cyc - lat1_rise + 1, TXN1);
            end
        end
        lat1_d = bus1.pad_latch;
    end

    // ---------------- stimulus ----------------
    task automatic wait_valid();
        int start = valid_cnt;
        for (int i = 0; i < 3 * P && valid_cnt == start; i++) @(negedge clk_sys);
        check("valid_timeout", (valid_cnt != start) ? 1 : 0, 1);
    endtask

    task automatic wait_latch();
        int start = latch_cnt;
        for (int i = 0; i < 3 * P && latch_cnt == start; i++) @(negedge clk_sys);
        check("latch_timeout", (latch_cnt != start) ? 1 : 0, 1);
    endtask

    task automatic new_stimulus(input int m, input logic [N-1:0] p);
        @(posedge clk_sys);
        #1;
        mode = m;
        pat  = p;
        pat1 = 1'($urandom_range(0, 1));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_latch"}, bus.pad_latch, 0);
        check({tag, "_pulse"}, bus.pad_pulse, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_valid"}, bus.valid, 0);
        check({tag, "_buttons"}, bus.buttons, 0);
        check({tag, "_n1_buttons"}, bus1.buttons, 0);
    endtask

    initial begin
        int lc;
        int en_cyc;
        bus.enable = 1'b0;
        mode = 0;
        pat  = 8'hA5;
        pat1 = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1 bus.enable = 1'b1;
        @(posedge clk_sys);
        #1 reset = 1'b0;
        @(negedge clk_sys);
        check_idle_outputs("reset");

        // A, Select, Down, Right; then unplugged; then stuck low; then random.
        wait_valid();
        new_stimulus(1, 8'h5A);
        wait_valid();
        new_stimulus(2, 8'h00);
        wait_valid();
        for (int t = 0; t < 6; t++) begin
            int m = int'($urandom_range(0, 3));
            new_stimulus((m == 3) ? 0 : m, N'($urandom));
            wait_valid();
        end

        // Reset in the middle of a transaction.
        new_stimulus(0, 8'h3C);
        wait_valid();
        new_stimulus(0, 8'h81);
        wait_latch();
        repeat (19) @(posedge clk_sys);
        #1 reset = 1'b1;
        @(posedge clk_sys);
        #1 reset = 1'b0;
        @(negedge clk_sys);
        check_idle_outputs("rst_mid");
        wait_valid();

        // Drop enable during PULSE_HI: transaction completes, then no new starts.
        new_stimulus(0, N'($urandom));
        wait_latch();
        for (int i = 0; i < 4 * H + L && !bus.pad_pulse; i++) @(negedge clk_sys);
        check("pulse_seen", bus.pad_pulse, 1);
        @(posedge clk_sys);
        #1 bus.enable = 1'b0;
        lc = latch_cnt;
        wait_valid();
        repeat (3 * P) @(negedge clk_sys);
        check("no_latch_disabled", latch_cnt, lc);
        new_stimulus(0, N'($urandom));
        bus.enable = 1'b1;
        en_cyc = cyc;
        wait_latch();
        check("resume_first_tick", (lat_rise - en_cyc >= 1 && lat_rise - en_cyc <= int'(P)) ? 1 : 0, 1);
        wait_valid();

        new_stimulus(0, N'($urandom));
        wait_valid();
        repeat (5) @(negedge clk_sys);
        check("queue_drained", exp_q.size(), 0);
        check("n1_queue_drained", exp1_q.size(), 0);
        check("n1_valid_count", valid1_cnt, latch1_cnt);
        check("n1_ran", (valid1_cnt > 5) ? 1 : 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got time %0t expected < 400000", $time);
        $fatal(1, "watchdog");
    end
endmodule
